// File: rtl/key_pattern_ctrl.sv
// Front-panel key controller: four raw buttons share one round-robin debounce
// timer, and the debounced presses step the LCD test-pattern index.
//
// state  | meaning
// IDLE   | nothing being debounced; grants the next pending key
// WAIT   | timing the debounce window for key sel (a release restarts it)
// SAMPLE | window elapsed; emit an event if key sel is still pressed
module key_pattern_ctrl #(
  parameter int unsigned T_DEBOUNCE = 32'd1_250_000,
  parameter int unsigned T_AUTO     = 32'd250_000_000,
  parameter int unsigned N_PATTERN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_evt,
  output logic [3:0] pattern_idx,
  output logic       auto_mode,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  localparam logic [31:0] DEB_LAST  = 32'(T_DEBOUNCE - 1);
  localparam logic [31:0] AUTO_LAST = 32'(T_AUTO - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(N_PATTERN - 1);

  state_t      state_q, state_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  sel_q, sel_d, rr_q, rr_d;
  logic [31:0] cnt_q, cnt_d, auto_cnt_q, auto_cnt_d;
  logic [3:0]  key_evt_q, key_evt_d;
  logic [3:0]  idx_q, idx_d;
  logic        auto_q, auto_d, busy_q, busy_d;
  logic [3:0]  fall, rise, pend_clr;
  logic [1:0]  cand;
  logic [3:0]  idx_next;

  always_comb begin
    s1_d = key_in;
    s2_d = s1_q;
    s3_d = s2_q;
    fall = s3_q & ~s2_q;
    rise = ~s3_q & s2_q;
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    pend_clr  = '0;
    key_evt_d = '0;
    cand      = rr_q;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          // Descending scan leaves cand at the first pending key from rr_q.
          for (int i = 3; i >= 0; i--) begin
            if (pending_q[rr_q + 2'(i)]) cand = rr_q + 2'(i);
          end
          sel_d   = cand;
          rr_d    = cand + 2'd1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rise[sel_q]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == DEB_LAST) state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        key_evt_d[sel_q] = ~s2_q[sel_q];
        pend_clr[sel_q]  = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (pending_q & ~pend_clr) | fall;
    busy_d    = (state_d != ST_IDLE);

    idx_next   = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
    idx_d      = idx_q;
    auto_d     = auto_q;
    auto_cnt_d = auto_q ? auto_cnt_q + 32'd1 : 32'd0;

    // A manual event takes priority over a coincident auto tick.
    if (|key_evt_d) begin
      auto_cnt_d = '0;
      if (key_evt_d[0]) idx_d = idx_next;
      if (key_evt_d[1]) idx_d = (idx_q == 4'd0) ? IDX_LAST : idx_q - 4'd1;
      if (key_evt_d[2]) auto_d = ~auto_q;
      if (key_evt_d[3]) begin
        idx_d  = '0;
        auto_d = 1'b0;
      end
    end else if (auto_q && (auto_cnt_q == AUTO_LAST)) begin
      auto_cnt_d = '0;
      idx_d      = idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= 4'hF;
      s2_q       <= 4'hF;
      s3_q       <= 4'hF;
      pending_q  <= '0;
      sel_q      <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      auto_cnt_q <= '0;
      key_evt_q  <= '0;
      idx_q      <= '0;
      auto_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      auto_cnt_q <= auto_cnt_d;
      key_evt_q  <= key_evt_d;
      idx_q      <= idx_d;
      auto_q     <= auto_d;
      busy_q     <= busy_d;
    end
  end

  assign key_evt     = key_evt_q;
  assign pattern_idx = idx_q;
  assign auto_mode   = auto_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_key_pattern_ctrl.sv
// Bench for key_pattern_ctrl: directed timing scenarios plus a randomized run
// against a deadline-based reference model of the debounce and pattern rules.
module tb_key_pattern_ctrl;
  localparam int TD = 16;
  localparam int TA = 50;
  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_evt, pattern_idx;
  logic       auto_mode, busy;

  int total = 0;
  int bad = 0;

  key_pattern_ctrl #(.T_DEBOUNCE(TD), .T_AUTO(TA), .N_PATTERN(NP)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_evt(key_evt),
    .pattern_idx(pattern_idx), .auto_mode(auto_mode), .busy(busy)
  );

  always #4 clk = ~clk;

  // Reference model: the debounce window is a deadline edge number, the auto
  // period a next-tick edge number; pattern index is plain modular arithmetic.
  longint     cyc = 0;
  longint     m_due = 0;
  longint     m_tick = 0;
  logic [3:0] ms1 = 4'hF, ms2 = 4'hF, ms3 = 4'hF;
  logic [3:0] m_pend = 4'h0, m_evt = 4'h0;
  int         m_phase = 0;
  int         m_sel = 0;
  int         m_rr = 0;
  int         m_idx = 0;
  logic       m_auto = 1'b0, m_busy = 1'b0;

  always @(posedge clk) begin : model
    logic [3:0] fall, rise, clr, ev;
    logic       found;
    cyc++;
    if (rst) begin
      ms1 = 4'hF; ms2 = 4'hF; ms3 = 4'hF;
      m_pend = 4'h0; m_evt = 4'h0; m_phase = 0; m_rr = 0;
      m_idx = 0; m_auto = 1'b0; m_busy = 1'b0;
    end else begin
      fall = ms3 & ~ms2;
      rise = ~ms3 & ms2;
      clr = 4'h0;
      ev = 4'h0;
      found = 1'b0;
      if (m_phase == 0) begin
        if (m_pend != 4'h0) begin
          for (int k = 0; k < 4; k++) begin
            if (!found && m_pend[(m_rr + k) % 4]) begin
              found = 1'b1;
              m_sel = (m_rr + k) % 4;
            end
          end
          m_rr = (m_sel + 1) % 4;
          m_due = cyc + TD;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (rise[m_sel]) m_due = cyc + TD;
        else if (cyc == m_due) m_phase = 2;
      end else begin
        if (!ms2[m_sel]) ev[m_sel] = 1'b1;
        clr[m_sel] = 1'b1;
        m_phase = 0;
      end
      m_pend = (m_pend & ~clr) | fall;
      if (ev != 4'h0) begin
        if (ev[0]) m_idx = (m_idx + 1) % NP;
        if (ev[1]) m_idx = (m_idx == 0) ? NP - 1 : m_idx - 1;
        if (ev[2]) m_auto = !m_auto;
        if (ev[3]) begin m_idx = 0; m_auto = 1'b0; end
        if (m_auto) m_tick = cyc + TA;
      end else if (m_auto && cyc == m_tick) begin
        m_idx = (m_idx + 1) % NP;
        m_tick = cyc + TA;
      end
      m_evt = ev;
      m_busy = (m_phase != 0);
      ms3 = ms2; ms2 = ms1; ms1 = key_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k, input int hold, output logic [3:0] seen);
    seen = 4'h0;
    key_in = ~(4'b0001 << k);
    for (int i = 0; i < hold; i++) begin step(); seen = seen | key_evt; end
    key_in = 4'hF;
    for (int i = 0; i < 8; i++) begin step(); seen = seen | key_evt; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 4'hF;
    repeat (3) step();
    total++;
    if ({key_evt, pattern_idx, auto_mode, busy} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got evt=%b idx=%0d auto=%b busy=%b, want all 0",
               key_evt, pattern_idx, auto_mode, busy);
    end
    rst = 1'b0;
    repeat (5) step();
    total++;
    if (busy !== 1'b0 || key_evt !== 4'h0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b evt=%b, want 0 0", busy, key_evt);
    end
  endtask

  task automatic test_clean_press();
    int first, nev, nbusy;
    first = -1; nev = 0; nbusy = 0;
    key_in = 4'b1110;
    for (int i = 0; i < 40; i++) begin
      step();
      if (key_evt != 4'h0) begin
        nev++;
        if (first < 0) first = i;
        total++;
        if (key_evt !== 4'b0001) begin
          bad++;
          $display("FAIL clean_evt_bits: got %b want 0001", key_evt);
        end
      end
      if (busy) nbusy++;
    end
    key_in = 4'hF;
    repeat (10) step();
    total++;
    if (first !== 20) begin bad++; $display("FAIL clean_evt_edge: got %0d want 20", first); end
    total++;
    if (nev !== 1) begin bad++; $display("FAIL clean_evt_count: got %0d want 1", nev); end
    total++;
    if (nbusy !== 17) begin bad++; $display("FAIL clean_busy_len: got %0d want 17", nbusy); end
    total++;
    if (pattern_idx !== 4'd1) begin bad++; $display("FAIL clean_idx: got %0d want 1", pattern_idx); end
  endtask

  task automatic test_wrap();
    logic [3:0] seen, all_seen;
    int         exp_idx [5] = '{0, 7, 0, 7, 0};
    int         keys [5] = '{1, 1, 0, 1, 0};
    all_seen = 4'h0;
    for (int n = 0; n < 5; n++) begin
      press_key(keys[n], 24, seen);
      all_seen = all_seen | seen;
      total++;
      if (pattern_idx !== 4'(exp_idx[n])) begin
        bad++;
        $display("FAIL wrap_idx_%0d: got %0d want %0d", n, pattern_idx, exp_idx[n]);
      end
    end
    total++;
    if (all_seen !== 4'b0011) begin
      bad++;
      $display("FAIL wrap_evt_mask: got %b want 0011", all_seen);
    end
  endtask

  task automatic test_bounce();
    int first, nev;
    first = -1; nev = 0;
    for (int j = 0; j < 90; j++) begin
      key_in = (j < 30 && ((j / 5) % 2) == 1) ? 4'hF : 4'b1101;
      step();
      if (key_evt != 4'h0) begin
        nev++;
        if (first < 0) first = j;
        total++;
        if (key_evt !== 4'b0010) begin
          bad++;
          $display("FAIL bounce_evt_bits: got %b want 0010", key_evt);
        end
      end
    end
    key_in = 4'hF;
    repeat (10) step();
    total++;
    if (first !== 44) begin bad++; $display("FAIL bounce_evt_edge: got %0d want 44", first); end
    total++;
    if (nev !== 1) begin bad++; $display("FAIL bounce_evt_count: got %0d want 1", nev); end
    total++;
    if (pattern_idx !== 4'd7) begin bad++; $display("FAIL bounce_idx: got %0d want 7", pattern_idx); end
  endtask

  task automatic test_abort();
    int   nev;
    logic saw_busy;
    nev = 0; saw_busy = 1'b0;
    for (int j = 0; j < 60; j++) begin
      key_in = (j < 8) ? 4'b1101 : 4'hF;
      step();
      if (key_evt != 4'h0) nev++;
      if (busy) saw_busy = 1'b1;
    end
    total++;
    if (nev !== 0) begin bad++; $display("FAIL abort_evt_count: got %0d want 0", nev); end
    total++;
    if (saw_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_seen: got %b want 1", saw_busy); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_end: got %b want 0", busy); end
    total++;
    if (pattern_idx !== 4'd7) begin bad++; $display("FAIL abort_idx: got %0d want 7", pattern_idx); end
  endtask

  task automatic test_arbitration();
    int         nev;
    int         ev_t [8];
    logic [3:0] ev_v [8];
    logic [3:0] exp_v;
    nev = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    key_in = 4'h0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (key_evt != 4'h0 && nev < 8) begin
        ev_t[nev] = i;
        ev_v[nev] = key_evt;
        nev++;
      end
    end
    key_in = 4'hF;
    repeat (10) step();
    total++;
    if (nev !== 4) begin bad++; $display("FAIL arb_evt_count: got %0d want 4", nev); end
    for (int n = 0; n < 4 && n < nev; n++) begin
      exp_v = 4'b0001 << n;
      total++;
      if (ev_t[n] !== 20 + 18 * n || ev_v[n] !== exp_v) begin
        bad++;
        $display("FAIL arb_evt_%0d: got edge %0d bits %b, want edge %0d bits %b",
                 n, ev_t[n], ev_v[n], 20 + 18 * n, exp_v);
      end
    end
    total++;
    if (pattern_idx !== 4'd0 || auto_mode !== 1'b0) begin
      bad++;
      $display("FAIL arb_final: got idx=%0d auto=%b want idx=0 auto=0", pattern_idx, auto_mode);
    end
  endtask

  task automatic test_auto();
    int         exp_idx;
    logic [3:0] exp_evt;
    for (int e = 0; e < 280; e++) begin
      key_in = 4'hF;
      if (e < 24) key_in[2] = 1'b0;
      if (e >= 150 && e < 175) key_in[0] = 1'b0;
      step();
      exp_idx = (e < 70) ? 0 : (e < 120) ? 1 : (e < 170) ? 2 : (e < 220) ? 3 : (e < 270) ? 4 : 5;
      exp_evt = (e == 20) ? 4'b0100 : (e == 170) ? 4'b0001 : 4'b0000;
      total++;
      if (pattern_idx !== 4'(exp_idx)) begin
        bad++;
        $display("FAIL auto_idx@%0d: got %0d want %0d", e, pattern_idx, exp_idx);
      end
      total++;
      if (key_evt !== exp_evt) begin
        bad++;
        $display("FAIL auto_evt@%0d: got %b want %b", e, key_evt, exp_evt);
      end
      total++;
      if (auto_mode !== (e >= 20)) begin
        bad++;
        $display("FAIL auto_mode@%0d: got %b want %b", e, auto_mode, (e >= 20));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] exp_evt;
    key_in = 4'b1110;
    for (int e = 0; e < 50; e++) begin
      rst = (e == 10);
      step();
      if (e == 9) begin
        total++;
        if (busy !== 1'b1 || pattern_idx !== 4'd5 || auto_mode !== 1'b1) begin
          bad++;
          $display("FAIL rstwait_pre: got busy=%b idx=%0d auto=%b want 1 5 1", busy, pattern_idx, auto_mode);
        end
      end
      if (e == 10) begin
        total++;
        if ({key_evt, pattern_idx, auto_mode, busy} !== 10'b0) begin
          bad++;
          $display("FAIL rstwait_zero: got evt=%b idx=%0d auto=%b busy=%b want all 0",
                   key_evt, pattern_idx, auto_mode, busy);
        end
      end
      exp_evt = (e == 31) ? 4'b0001 : 4'b0000;
      total++;
      if (key_evt !== exp_evt) begin
        bad++;
        $display("FAIL rstwait_evt@%0d: got %b want %b", e, key_evt, exp_evt);
      end
    end
    rst = 1'b0;
    key_in = 4'hF;
    repeat (10) step();
    total++;
    if (pattern_idx !== 4'd1 || auto_mode !== 1'b0) begin
      bad++;
      $display("FAIL rstwait_final: got idx=%0d auto=%b want 1 0", pattern_idx, auto_mode);
    end
  endtask

  task automatic test_random();
    int hold;
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        key_in = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 40);
      end
      hold--;
      rst = ($urandom_range(0, 499) == 0);
      step();
      total++;
      if ({key_evt, pattern_idx, auto_mode, busy} !== {m_evt, 4'(m_idx), m_auto, m_busy}) begin
        bad++;
        $display("FAIL rand@%0d: got evt=%b idx=%0d auto=%b busy=%b want evt=%b idx=%0d auto=%b busy=%b",
                 c, key_evt, pattern_idx, auto_mode, busy, m_evt, m_idx, m_auto, m_busy);
      end
    end
    rst = 1'b0;
    key_in = 4'hF;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_wrap();
    test_bounce();
    test_abort();
    test_arbitration();
    test_auto();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
